// File: rtl/sc_level_pkg.sv
// Shared definitions for the level sequencer: default parameter values,
// state encoding and a legality helper for the state register.
package sc_level_pkg;

   localparam int NUM_LEVELS_DEF         = 3;
   localparam int LEVEL_DATAWIDTH_DEF    = 3;
   localparam int PROGRESS_DATAWIDTH_DEF = 5;
   localparam int GOAL_COUNT_DEF         = 5;
   localparam int LIVES_INIT_DEF         = 3;
   localparam int LIVES_WIDTH            = 3;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_PLAYING    = 3'd1,
      ST_LEVEL_DONE = 3'd2,
      ST_WIN        = 3'd3,
      ST_GAMEOVER   = 3'd4
   } levelStateT;

   // True for the five defined encodings; anything else is a corrupted register.
   function automatic logic isLegalState(input levelStateT st);
      return (st == ST_IDLE) || (st == ST_PLAYING) || (st == ST_LEVEL_DONE) ||
             (st == ST_WIN)  || (st == ST_GAMEOVER);
   endfunction

endpackage

// File: rtl/sc_level_progress_counter.sv
// Per-level goal counter: synchronous clear, increment, saturation at GOAL.
// The done flag marks the increment that completes the level, so the
// sequencer can move on in the same cycle the last goal arrives.
module sc_level_progress_counter
   import sc_level_pkg::*;
#(
   parameter int WIDTH = PROGRESS_DATAWIDTH_DEF,
   parameter int GOAL  = GOAL_COUNT_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             increment,
   output logic [WIDTH-1:0] count,
   output logic             done
);

   localparam logic [WIDTH-1:0] GOAL_V = WIDTH'(GOAL);

   // Count goals; clear wins over increment, and the count never passes GOAL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (increment && (count != GOAL_V))
         count <= count + 1'b1;
   end

   assign done = increment && (count == GOAL_V - 1'b1);

endmodule

// File: rtl/sc_level_sequencer.sv
// Level sequencer for the frog game: start press, per-level goal tracking,
// level advance, win / game-over hold and restart.
// Optional lives feature: define SC_LEVEL_SEQUENCER_LIVES_EN to add the lives
// counter, the Lives_Out port and death handling.
module sc_level_sequencer
   import sc_level_pkg::*;
#(
   parameter int NUM_LEVELS         = NUM_LEVELS_DEF,
   parameter int LEVEL_DATAWIDTH    = LEVEL_DATAWIDTH_DEF,
   parameter int PROGRESS_DATAWIDTH = PROGRESS_DATAWIDTH_DEF,
   parameter int GOAL_COUNT         = GOAL_COUNT_DEF,
   parameter int LIVES_INIT         = LIVES_INIT_DEF
)(
   input  logic                          SC_LEVEL_SEQUENCER_CLOCK_50,
   input  logic                          SC_LEVEL_SEQUENCER_RESET_InHigh,
   input  logic                          SC_LEVEL_SEQUENCER_StartSignal_InLow,
   input  logic                          SC_LEVEL_SEQUENCER_GoalReached_InHigh,
   input  logic                          SC_LEVEL_SEQUENCER_Death_InHigh,
   output logic [LEVEL_DATAWIDTH-1:0]    SC_LEVEL_SEQUENCER_CurrentLevel_Out,
   output logic [PROGRESS_DATAWIDTH-1:0] SC_LEVEL_SEQUENCER_LvlProgressCount_Out,
   output logic                          SC_LEVEL_SEQUENCER_StartCount_Out,
   output logic                          SC_LEVEL_SEQUENCER_LevelFinished_Out,
   output logic                          SC_LEVEL_SEQUENCER_FinishedGame_Out,
   output logic                          SC_LEVEL_SEQUENCER_GameWon_Out
`ifdef SC_LEVEL_SEQUENCER_LIVES_EN
   ,
   output logic [LIVES_WIDTH-1:0]        SC_LEVEL_SEQUENCER_Lives_Out
`endif
);

   logic clk, rst, startN, goal, death;
   assign clk    = SC_LEVEL_SEQUENCER_CLOCK_50;
   assign rst    = SC_LEVEL_SEQUENCER_RESET_InHigh;
   assign startN = SC_LEVEL_SEQUENCER_StartSignal_InLow;
   assign goal   = SC_LEVEL_SEQUENCER_GoalReached_InHigh;
   assign death  = SC_LEVEL_SEQUENCER_Death_InHigh;

   levelStateT                  stateReg, stateNext;
   logic                        prevStart, press;
   logic [LEVEL_DATAWIDTH-1:0]  levelReg;
   logic                        lastLevel, stateLegal, finishedState;
   logic                        progClear, progInc, progDone;
   logic [PROGRESS_DATAWIDTH-1:0] progCount;

   // Press = falling edge of the active-low button; resetting prevStart high
   // means a button already low when reset releases counts as one press.
   assign press         = prevStart & ~startN;
   assign lastLevel     = (levelReg == LEVEL_DATAWIDTH'(NUM_LEVELS));
   assign stateLegal    = isLegalState(stateReg);
   assign finishedState = (stateReg == ST_WIN) || (stateReg == ST_GAMEOVER);

   // Remember last button level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prevStart <= 1'b1;
      else     prevStart <= startN;
   end

`ifdef SC_LEVEL_SEQUENCER_LIVES_EN
   logic [LIVES_WIDTH-1:0] livesReg;

   // Lives: refilled on game start, one lost per death in play (goal wins ties).
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         livesReg <= LIVES_WIDTH'(LIVES_INIT);
      else if ((stateReg == ST_IDLE) && press)
         livesReg <= LIVES_WIDTH'(LIVES_INIT);
      else if ((stateReg == ST_PLAYING) && death && !goal && (livesReg != '0))
         livesReg <= livesReg - 1'b1;
   end

   assign SC_LEVEL_SEQUENCER_Lives_Out = livesReg;
`else
   // Without lives, death has no effect and the initial-lives setting is moot.
   logic unusedCfg;
   assign unusedCfg = death | (LIVES_INIT != 0);
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stateReg <= ST_IDLE;
      else     stateReg <= stateNext;
   end

   // Next-state decode; a goal completing the level beats a same-cycle death.
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         ST_IDLE:       if (press) stateNext = ST_PLAYING;
         ST_PLAYING: begin
            if (progDone)
               stateNext = ST_LEVEL_DONE;
`ifdef SC_LEVEL_SEQUENCER_LIVES_EN
            else if (death && !goal && (livesReg == LIVES_WIDTH'(1)))
               stateNext = ST_GAMEOVER;
`endif
         end
         ST_LEVEL_DONE: stateNext = lastLevel ? ST_WIN : ST_PLAYING;
         ST_WIN,
         ST_GAMEOVER:   if (press) stateNext = ST_IDLE;
         default:       stateNext = ST_IDLE;
      endcase
   end

   // Level number: 1 on start, +1 per finished level, 0 on return to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         levelReg <= '0;
      else if (!stateLegal)
         levelReg <= '0;
      else if ((stateReg == ST_IDLE) && press)
         levelReg <= LEVEL_DATAWIDTH'(1);
      else if ((stateReg == ST_LEVEL_DONE) && !lastLevel)
         levelReg <= levelReg + 1'b1;
      else if (finishedState && press)
         levelReg <= '0;
   end

   // Progress is held at zero in idle, restarted for each new level, and
   // left frozen at the goal value once the final level is done.
   assign progClear = (stateReg == ST_IDLE) || !stateLegal ||
                      ((stateReg == ST_LEVEL_DONE) && !lastLevel) ||
                      (finishedState && press);
   assign progInc   = (stateReg == ST_PLAYING) && goal;

   sc_level_progress_counter #(
      .WIDTH (PROGRESS_DATAWIDTH),
      .GOAL  (GOAL_COUNT)
   ) uProgress (
      .clk       (clk),
      .rst       (rst),
      .clear     (progClear),
      .increment (progInc),
      .count     (progCount),
      .done      (progDone)
   );

   // Moore outputs decoded from registered state and counters.
   always_comb begin
      SC_LEVEL_SEQUENCER_CurrentLevel_Out     = levelReg;
      SC_LEVEL_SEQUENCER_LvlProgressCount_Out = progCount;
      SC_LEVEL_SEQUENCER_StartCount_Out       = (stateReg == ST_PLAYING);
      SC_LEVEL_SEQUENCER_LevelFinished_Out    = (stateReg == ST_LEVEL_DONE);
      SC_LEVEL_SEQUENCER_FinishedGame_Out     = finishedState;
      SC_LEVEL_SEQUENCER_GameWon_Out          = (stateReg == ST_WIN);
   end

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Directed bench for sc_level_sequencer (default parameters). Lives checks
// are included when SC_LEVEL_SEQUENCER_LIVES_EN is defined.
module tb_sc_level_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       startN = 1'b1;
   logic       goal = 1'b0;
   logic       death = 1'b0;
   logic [2:0] level;
   logic [4:0] progress;
   logic       startCount, levelFinished, finishedGame, gameWon;
`ifdef SC_LEVEL_SEQUENCER_LIVES_EN
   logic [2:0] lives;
`endif

   int vecCount = 0;
   int errCount = 0;

   always #5 clk = ~clk;

   sc_level_sequencer dut (
      .SC_LEVEL_SEQUENCER_CLOCK_50             (clk),
      .SC_LEVEL_SEQUENCER_RESET_InHigh         (rst),
      .SC_LEVEL_SEQUENCER_StartSignal_InLow    (startN),
      .SC_LEVEL_SEQUENCER_GoalReached_InHigh   (goal),
      .SC_LEVEL_SEQUENCER_Death_InHigh         (death),
      .SC_LEVEL_SEQUENCER_CurrentLevel_Out     (level),
      .SC_LEVEL_SEQUENCER_LvlProgressCount_Out (progress),
      .SC_LEVEL_SEQUENCER_StartCount_Out       (startCount),
      .SC_LEVEL_SEQUENCER_LevelFinished_Out    (levelFinished),
      .SC_LEVEL_SEQUENCER_FinishedGame_Out     (finishedGame),
      .SC_LEVEL_SEQUENCER_GameWon_Out          (gameWon)
`ifdef SC_LEVEL_SEQUENCER_LIVES_EN
      ,
      .SC_LEVEL_SEQUENCER_Lives_Out            (lives)
`endif
   );

   // Observed word: {level[2:0], progress[4:0], startCount, levelFinished, finishedGame, gameWon}
   logic [11:0] obs;
   assign obs = {level, progress, startCount, levelFinished, finishedGame, gameWon};

   function automatic logic [11:0] ex(input int lvl, input int prog,
                                      input bit sc, input bit lf, input bit fin, input bit won);
      return {3'(lvl), 5'(prog), sc, lf, fin, won};
   endfunction

   typedef struct {
      logic        s;
      logic        g;
      logic        d;
      logic [11:0] exp;
   } vecT;

   vecT tbl[25];

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      vecCount++;
      if (act !== exp) begin
         errCount++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle with the given inputs; sample 1 ns after the edge.
   task automatic step(input logic s, input logic g, input logic d);
      startN = s;
      goal   = g;
      death  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1; startN = 1'b1; goal = 1'b0; death = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_outputs", obs, ex(0, 0, 0, 0, 0, 0));
`ifdef SC_LEVEL_SEQUENCER_LIVES_EN
      chk("reset_lives", 12'(lives), 12'd3);
`endif
      rst = 1'b0;
   endtask

   initial begin
      // Full game: two presses held/ignored, goal+death tie, three levels, win, restart.
      tbl[0]  = '{1'b0, 1'b0, 1'b0, ex(1, 0, 1, 0, 0, 0)};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, ex(1, 0, 1, 0, 0, 0)};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, ex(1, 1, 1, 0, 0, 0)};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, ex(1, 2, 1, 0, 0, 0)};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, ex(1, 3, 1, 0, 0, 0)};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, ex(1, 4, 1, 0, 0, 0)};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, ex(1, 5, 0, 1, 0, 0)};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, ex(2, 0, 1, 0, 0, 0)};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, ex(2, 1, 1, 0, 0, 0)};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, ex(2, 2, 1, 0, 0, 0)};
      tbl[10] = '{1'b1, 1'b1, 1'b0, ex(2, 3, 1, 0, 0, 0)};
      tbl[11] = '{1'b1, 1'b1, 1'b0, ex(2, 4, 1, 0, 0, 0)};
      tbl[12] = '{1'b1, 1'b1, 1'b0, ex(2, 5, 0, 1, 0, 0)};
      tbl[13] = '{1'b1, 1'b0, 1'b0, ex(3, 0, 1, 0, 0, 0)};
      tbl[14] = '{1'b1, 1'b1, 1'b0, ex(3, 1, 1, 0, 0, 0)};
      tbl[15] = '{1'b1, 1'b1, 1'b0, ex(3, 2, 1, 0, 0, 0)};
      tbl[16] = '{1'b1, 1'b1, 1'b0, ex(3, 3, 1, 0, 0, 0)};
      tbl[17] = '{1'b1, 1'b1, 1'b0, ex(3, 4, 1, 0, 0, 0)};
      tbl[18] = '{1'b1, 1'b1, 1'b0, ex(3, 5, 0, 1, 0, 0)};
      tbl[19] = '{1'b1, 1'b0, 1'b0, ex(3, 5, 0, 0, 1, 1)};
      tbl[20] = '{1'b1, 1'b1, 1'b1, ex(3, 5, 0, 0, 1, 1)};
      tbl[21] = '{1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0)};
      tbl[22] = '{1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0)};
      tbl[23] = '{1'b1, 1'b1, 1'b0, ex(0, 0, 0, 0, 0, 0)};
      tbl[24] = '{1'b0, 1'b0, 1'b0, ex(1, 0, 1, 0, 0, 0)};

      #1;
      doReset();
      for (int i = 0; i < 25; i++) begin
         step(tbl[i].s, tbl[i].g, tbl[i].d);
         chk($sformatf("vec%0d", i), obs, tbl[i].exp);
`ifdef SC_LEVEL_SEQUENCER_LIVES_EN
         chk($sformatf("vec%0d_lives", i), 12'(lives), 12'd3);
`endif
      end

      // Button held low for 10 cycles: one start, stays level 1 in play.
      doReset();
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b0);
         chk($sformatf("held_press%0d", i), obs, ex(1, 0, 1, 0, 0, 0));
      end
      step(1'b1, 1'b0, 1'b0);
      chk("held_release", obs, ex(1, 0, 1, 0, 0, 0));

      // Three deaths in play.
`ifdef SC_LEVEL_SEQUENCER_LIVES_EN
      step(1'b1, 1'b0, 1'b1);
      chk("death1_lives", 12'(lives), 12'd2);
      step(1'b1, 1'b0, 1'b1);
      chk("death2_lives", 12'(lives), 12'd1);
      chk("death2_state", obs, ex(1, 0, 1, 0, 0, 0));
      step(1'b1, 1'b0, 1'b1);
      chk("gameover_lives", 12'(lives), 12'd0);
      chk("gameover_state", obs, ex(1, 0, 0, 0, 1, 0));
      step(1'b1, 1'b1, 1'b1);
      chk("gameover_hold", obs, ex(1, 0, 0, 0, 1, 0));
      step(1'b0, 1'b0, 1'b0);
      chk("gameover_press", obs, ex(0, 0, 0, 0, 0, 0));
`else
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1);
         chk($sformatf("death%0d_ignored", i), obs, ex(1, 0, 1, 0, 0, 0));
      end
      step(1'b1, 1'b1, 1'b0);
      chk("goal_after_deaths", obs, ex(1, 1, 1, 0, 0, 0));
`endif

      // Reset asserted in the middle of the LEVEL_DONE cycle.
      doReset();
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("pre_reset_level_done", obs, ex(1, 5, 0, 1, 0, 0));
      goal = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", obs, ex(0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      chk("after_reset_idle", obs, ex(0, 0, 0, 0, 0, 0));
      step(1'b1, 1'b1, 1'b0);
      chk("after_reset_goal_ignored", obs, ex(0, 0, 0, 0, 0, 0));
      step(1'b0, 1'b0, 1'b0);
      chk("after_reset_press", obs, ex(1, 0, 1, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule

// File: doc/sc_level_sequencer.md
SC_LEVEL_SEQUENCER -- requirements
Module: SC_LEVEL_SEQUENCER

Interface
REQ-001 Parameter NUM_LEVELS, default 3, number of playable levels (1..7) before game won.
REQ-002 Parameter LEVEL_DATAWIDTH, default 3, width of level number; SHALL hold NUM_LEVELS.
REQ-003 Parameter PROGRESS_DATAWIDTH, default 5, width of per-level progress counter.
REQ-004 Parameter GOAL_COUNT, default 5, goals needed to finish a level (1..2^PROGRESS_DATAWIDTH-1).
REQ-005 Parameter LIVES_INIT, default 3, lives granted at game start (used only with lives feature).
REQ-006 SC_LEVEL_SEQUENCER_CLOCK_50  in  1  system clock, all state on rising edge.
REQ-007 SC_LEVEL_SEQUENCER_RESET_InHigh  in  1  asynchronous, active-high reset.
REQ-008 SC_LEVEL_SEQUENCER_StartSignal_InLow  in  1  start button, active low, already synchronised.
REQ-009 SC_LEVEL_SEQUENCER_GoalReached_InHigh  in  1  one-cycle pulse: frog reached home.
REQ-010 SC_LEVEL_SEQUENCER_Death_InHigh  in  1  one-cycle pulse: frog died.
REQ-011 SC_LEVEL_SEQUENCER_CurrentLevel_Out  out  LEVEL_DATAWIDTH  active level, 0 when no game.
REQ-012 SC_LEVEL_SEQUENCER_LvlProgressCount_Out  out  PROGRESS_DATAWIDTH  goals reached in current level.
REQ-013 SC_LEVEL_SEQUENCER_StartCount_Out  out  1  high while a level is in play (enables timers/traffic).
REQ-014 SC_LEVEL_SEQUENCER_LevelFinished_Out  out  1  one-cycle pulse on level completion.
REQ-015 SC_LEVEL_SEQUENCER_FinishedGame_Out  out  1  high in WIN or GAMEOVER.
REQ-016 SC_LEVEL_SEQUENCER_GameWon_Out  out  1  high only in WIN.
REQ-017 SC_LEVEL_SEQUENCER_Lives_Out  out  3  remaining lives (present only with lives feature).

Function
REQ-018 States SHALL be IDLE, PLAYING, LEVEL_DONE, WIN, GAMEOVER; outputs Moore-decoded from registered state/counters.
REQ-019 A "press" SHALL be a falling edge of StartSignal_InLow, detected with a registered previous value (reset value 1); a held-low button yields exactly one press.
REQ-020 IDLE + press -> PLAYING next edge; level=1, progress=0, lives=LIVES_INIT.
REQ-021 PLAYING: each GoalReached pulse SHALL increment progress by 1; when progress==GOAL_COUNT-1 and GoalReached, next state LEVEL_DONE with progress=GOAL_COUNT.
REQ-022 LEVEL_DONE SHALL last exactly one cycle with LevelFinished_Out=1 and StartCount_Out=0.
REQ-023 LEVEL_DONE -> WIN if level==NUM_LEVELS, else -> PLAYING with level+1 and progress=0.
REQ-024 GoalReached and Death in same cycle: goal SHALL take priority; death ignored.
REQ-025 Pulses on GoalReached/Death outside PLAYING SHALL be ignored; progress never exceeds GOAL_COUNT.
REQ-026 WIN/GAMEOVER hold FinishedGame_Out=1, level and progress frozen; press -> IDLE (level=0, progress=0).
REQ-027 Press while PLAYING or LEVEL_DONE SHALL be ignored.
REQ-028 Illegal state encodings SHALL recover to IDLE next edge.

Reset
REQ-029 Reset assertion SHALL immediately force IDLE, level 0, progress 0, lives LIVES_INIT, all flag outputs 0, previous-start register 1, regardless of operation in progress.
REQ-030 First press after reset release SHALL be honoured only as a genuine falling edge.

Configuration
REQ-031 Macro SC_LEVEL_SEQUENCER_LIVES_EN defined: lives counter and Lives_Out exist; Death in PLAYING decrements lives; Death with lives==1 -> GAMEOVER (lives=0); progress unchanged on death.
REQ-032 Macro undefined: no lives counter, no Lives_Out port, Death ignored, GAMEOVER unreachable.

Structure
REQ-033 Shared package sc_level_pkg SHALL hold state encoding constants and default parameter values.
REQ-034 One sub-module SC_LEVEL_PROGRESS_COUNTER (clear, increment, saturate at GOAL_COUNT, done flag) SHALL implement the progress counter.

Verification
REQ-035 Reset, press held low 10 cycles -> one transition to PLAYING, level=1, StartCount=1.
REQ-036 Defaults, 5 GoalReached pulses -> LevelFinished one cycle, level=2, progress=0; 15 total -> WIN, GameWon=1, level=3.
REQ-037 Goal and Death same cycle at progress=4 -> LEVEL_DONE, lives stay 3.
REQ-038 LIVES_EN, 3 Death pulses -> GAMEOVER, Lives=0, FinishedGame=1; press -> IDLE, level=0.
REQ-039 Reset asserted mid-LEVEL_DONE -> outputs zero same cycle, IDLE after release.
